// File: rtl/arbiter_req_bot.sv
// Automated contestant for the two-player arbiter game: raises one request line
// after a pseudo-random reaction delay and holds it until the round resolves or times out.
module arbiter_req_bot #(
  parameter int         CLOCK_FREQ      = 1000,
  parameter int         PRESCALER_COUNT = 250,
  parameter int         MIN_DELAY       = 2,
  parameter int         HOLD_TICKS      = 4,
  parameter logic [7:0] LFSR_SEED       = 8'hA5
) (
  input  logic       clk,
  input  logic       rst_in,
  input  logic       enable_in,
  input  logic       arm_in,
  input  logic       grant_in,
  input  logic       round_over_in,
  output logic       req_out,
  output logic       busy_out,
  output logic [4:0] delay_out,
  output logic [3:0] win_cnt_out
);

  localparam int         PW        = $clog2(PRESCALER_COUNT);
  localparam int         HW        = $clog2(HOLD_TICKS + 1);
  localparam logic [7:0] SEED_EFF  = (LFSR_SEED == 8'h00) ? 8'h01 : LFSR_SEED;

  generate
    if (PRESCALER_COUNT < 2 || MIN_DELAY < 1 || MIN_DELAY > 16 || HOLD_TICKS < 1 || CLOCK_FREQ < 1) begin : g_param_check
      $error("arbiter_req_bot: illegal parameter value");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_WAIT     = 2'd1,
    S_REQ      = 2'd2,
    S_COOLDOWN = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [4:0]    delay_cnt_q, delay_cnt_d;
  logic [HW-1:0] hold_cnt_q, hold_cnt_d;
  logic [7:0]    lfsr_q, lfsr_d;
  logic [4:0]    delay_q, delay_d;
  logic [3:0]    win_q, win_d;
  logic          req_q, busy_q;
  logic          tick_s;
  logic [4:0]    new_delay_s;

  assign tick_s      = (presc_q == PW'(PRESCALER_COUNT - 1));
  assign new_delay_s = 5'(MIN_DELAY) + {1'b0, lfsr_q[3:0]};

  always_comb begin
    state_d     = state_q;
    presc_d     = tick_s ? '0 : presc_q + PW'(1);
    delay_cnt_d = delay_cnt_q;
    hold_cnt_d  = hold_cnt_q;
    delay_d     = delay_q;
    win_d       = win_q;
    lfsr_d      = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

    if (!enable_in) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (arm_in) begin
            delay_d     = new_delay_s;
            delay_cnt_d = new_delay_s;
            presc_d     = '0;
            state_d     = S_WAIT;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_WAIT: begin
          // Opponent already won before we fired: skip the request entirely.
          if (round_over_in) begin
            state_d = S_COOLDOWN;
          end else if (tick_s) begin
            if (delay_cnt_q == 5'd1) begin
              hold_cnt_d = HW'(HOLD_TICKS);
              presc_d    = '0;
              state_d    = S_REQ;
            end else begin
              delay_cnt_d = delay_cnt_q - 5'd1;
            end
          end else begin
            state_d = S_WAIT;
          end
        end
        S_REQ: begin
          if (grant_in) begin
            win_d   = (win_q != 4'd15) ? win_q + 4'd1 : win_q;
            state_d = S_COOLDOWN;
          end else if (round_over_in) begin
            state_d = S_COOLDOWN;
          end else if (tick_s) begin
            if (hold_cnt_q == HW'(1)) begin
              state_d = S_COOLDOWN;
            end else begin
              hold_cnt_d = hold_cnt_q - HW'(1);
            end
          end else begin
            state_d = S_REQ;
          end
        end
        S_COOLDOWN: begin
          // A held arm level must not start another round.
          if (!arm_in) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_COOLDOWN;
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst_in) begin
      state_q     <= S_IDLE;
      presc_q     <= '0;
      delay_cnt_q <= 5'd0;
      hold_cnt_q  <= '0;
      lfsr_q      <= SEED_EFF;
      delay_q     <= 5'd0;
      win_q       <= 4'd0;
      req_q       <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      presc_q     <= presc_d;
      delay_cnt_q <= delay_cnt_d;
      hold_cnt_q  <= hold_cnt_d;
      lfsr_q      <= lfsr_d;
      delay_q     <= delay_d;
      win_q       <= win_d;
      // Output decodes lag the state by one cycle; enable low clears them at once.
      req_q       <= (state_q == S_REQ) && enable_in;
      busy_q      <= (state_q != S_IDLE) && enable_in;
    end
  end

  assign req_out     = req_q;
  assign busy_out    = busy_q;
  assign delay_out   = delay_q;
  assign win_cnt_out = win_q;

endmodule

// File: tb/tb_arbiter_req_bot.sv
// Directed self-checking bench for arbiter_req_bot (P=4, MIN_DELAY=2, HOLD_TICKS=4);
// a second instance with seed 0 checks the zero-seed substitution.
module tb_arbiter_req_bot;

  logic       clk = 1'b0;
  logic       rst_in, enable_in, arm_in, grant_in, round_over_in;
  logic       req_out, busy_out;
  logic [4:0] delay_out;
  logic [3:0] win_cnt_out;
  logic       req2_out, busy2_out;
  logic [4:0] delay2_out;
  logic [3:0] win2_cnt_out;

  int err_cnt = 0;
  int chk_cnt = 0;

  always #5 clk = ~clk;

  arbiter_req_bot #(
    .PRESCALER_COUNT(4), .MIN_DELAY(2), .HOLD_TICKS(4), .LFSR_SEED(8'hA5)
  ) dut (
    .clk(clk), .rst_in(rst_in), .enable_in(enable_in), .arm_in(arm_in),
    .grant_in(grant_in), .round_over_in(round_over_in),
    .req_out(req_out), .busy_out(busy_out), .delay_out(delay_out), .win_cnt_out(win_cnt_out)
  );

  arbiter_req_bot #(
    .PRESCALER_COUNT(4), .MIN_DELAY(2), .HOLD_TICKS(4), .LFSR_SEED(8'h00)
  ) dut_seed0 (
    .clk(clk), .rst_in(rst_in), .enable_in(enable_in), .arm_in(arm_in),
    .grant_in(grant_in), .round_over_in(round_over_in),
    .req_out(req2_out), .busy_out(busy2_out), .delay_out(delay2_out), .win_cnt_out(win2_cnt_out)
  );

  task automatic check_val(input string tag, input int obs, input int exp);
    chk_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance n rising edges, then settle 1 time unit before sampling/driving.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_req(input int limit, output int n);
    n = 0;
    while (!req_out && n < limit) begin
      step(1);
      n++;
    end
  endtask

  initial begin
    int n;
    int hi;
    int seen;
    int exp_win;

    rst_in = 1'b1; enable_in = 1'b1; arm_in = 1'b0; grant_in = 1'b0; round_over_in = 1'b0;
    step(3);
    check_val("rst_req", int'(req_out), 0);
    check_val("rst_busy", int'(busy_out), 0);
    check_val("rst_delay", int'(delay_out), 0);
    check_val("rst_win", int'(win_cnt_out), 0);

    // Test 1: arm on first cycle after release; D = 2 + 5 = 7, rise at 7*4+1 = 29.
    rst_in = 1'b0; arm_in = 1'b1;
    step(1);
    check_val("t1_delay", int'(delay_out), 7);
    check_val("t6_seed0_delay", int'(delay2_out), 3);
    step(1);
    check_val("t1_busy", int'(busy_out), 1);
    wait_req(200, n);
    check_val("t1_rise_cycle", n + 1, 29);

    // Test 2: grant 3 cycles after rise, then cooldown while arm held.
    step(2);
    grant_in = 1'b1;
    step(1);
    grant_in = 1'b0;
    step(1);
    check_val("t2_req_drop", int'(req_out), 0);
    check_val("t2_win", int'(win_cnt_out), 1);
    step(5);
    check_val("t2_cd_busy", int'(busy_out), 1);
    check_val("t2_cd_req", int'(req_out), 0);
    check_val("t2_cd_delay", int'(delay_out), 7);
    arm_in = 1'b0;
    step(1);
    check_val("t2_busy_lag", int'(busy_out), 1);
    step(1);
    check_val("t2_idle_busy", int'(busy_out), 0);

    // Test 3: no grant -> request held exactly 16 cycles, win unchanged.
    arm_in = 1'b1;
    wait_req(200, n);
    check_val("t3_rose", int'(n < 200), 1);
    hi = 0;
    while (req_out && hi < 100) begin
      hi++;
      step(1);
    end
    check_val("t3_hold_len", hi, 16);
    check_val("t3_win", int'(win_cnt_out), 1);
    check_val("t3_cd_busy", int'(busy_out), 1);
    arm_in = 1'b0;
    step(2);

    // Test 4a: round_over during WAIT -> no request, cooldown.
    arm_in = 1'b1;
    step(1);
    step(3);
    round_over_in = 1'b1;
    step(1);
    round_over_in = 1'b0;
    seen = 0;
    repeat (150) begin
      step(1);
      if (req_out) seen = 1;
    end
    check_val("t4_no_req", seen, 0);
    check_val("t4_cd_busy", int'(busy_out), 1);
    arm_in = 1'b0;
    step(2);

    // Test 4b: grant coincides with final hold tick (16 edges after REQ entry).
    arm_in = 1'b1;
    wait_req(200, n);
    check_val("t4b_rose", int'(n < 200), 1);
    step(14);
    check_val("t4b_still_req", int'(req_out), 1);
    grant_in = 1'b1;
    step(1);
    grant_in = 1'b0;
    step(1);
    check_val("t4b_req_drop", int'(req_out), 0);
    check_val("t4b_win", int'(win_cnt_out), 2);
    arm_in = 1'b0;
    step(2);

    // Test 5a: enable dropped mid-REQ.
    arm_in = 1'b1;
    wait_req(200, n);
    check_val("t5_rose", int'(n < 200), 1);
    step(3);
    enable_in = 1'b0;
    step(1);
    check_val("t5_en_req", int'(req_out), 0);
    check_val("t5_en_busy", int'(busy_out), 0);
    arm_in = 1'b0;
    enable_in = 1'b1;
    step(2);
    check_val("t5_en_win", int'(win_cnt_out), 2);

    // Test 5b: reset mid-WAIT; re-arm right after release must reproduce D = 7.
    arm_in = 1'b1;
    step(1);
    step(4);
    rst_in = 1'b1;
    step(1);
    check_val("t5_rst_req", int'(req_out), 0);
    check_val("t5_rst_busy", int'(busy_out), 0);
    check_val("t5_rst_delay", int'(delay_out), 0);
    check_val("t5_rst_win", int'(win_cnt_out), 0);
    rst_in = 1'b0;
    step(1);
    check_val("t5_rst_lfsr_delay", int'(delay_out), 7);

    // Test 6: 17 won rounds, counter saturates at 15.
    for (int i = 1; i <= 17; i++) begin
      arm_in = 1'b1;
      wait_req(200, n);
      grant_in = 1'b1;
      step(1);
      grant_in = 1'b0;
      exp_win = (i > 15) ? 15 : i;
      check_val($sformatf("t6_win_%0d", i), int'(win_cnt_out), exp_win);
      arm_in = 1'b0;
      step(3);
    end

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
